task_answer_framer: RTL and testbench

- Downstream neighbour of each task wrapper.
- Consumes the task_out_interface answer stream: 32-bit words, last flag, byte count and latency.
- Buffers one answer and serialises it as a byte-wide framed packet (sync, header, payload, optional checksum) toward the UART TX stage.
- The answer side has no backpressure (the upstream width converter's ready is tied high), so this block absorbs words at full rate.

---
 rtl/task_answer_pkg.sv | 38 +++
 rtl/answer_word_fifo.sv | 52 +++++
 rtl/task_answer_framer.sv | 213 +++++++++++++++++++++
 tb/tb_task_answer_framer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/task_answer_pkg.sv
// Shared types and helpers for the task answer framer.
// The CSUM state exists only when TASK_ANSWER_FRAMER_CHECKSUM_EN is defined.
package task_answer_pkg;

    localparam int         HDR_BYTES         = 9;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SIZE,
        LAT,
        PAYLOAD,
        DISCARD
`ifdef TASK_ANSWER_FRAMER_CHECKSUM_EN
        ,
        CSUM
`endif
    } framer_state_e;

    typedef struct packed {
        logic [31:0] words;
        logic [31:0] size;
        logic [31:0] latency;
    } answer_desc_t;

    // Bytes actually framed: never more than the words that were delivered.
    function automatic logic [31:0] eff_bytes(input logic [31:0] size, input logic [31:0] words);
        logic [31:0] cap;
        cap = words << 2;
        return (size < cap) ? size : cap;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
        return word[8*idx +: 8];
    endfunction

endpackage

// File: rtl/answer_word_fifo.sv
// Synchronous 32-bit word FIFO with head and next-after-head peek ports.
module answer_word_fifo #(
    parameter int DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [31:0]            push_data,
    input  logic                   pop,
    output logic [31:0]            head_data,
    output logic [31:0]            next_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/task_answer_framer.sv
// Buffers one task answer and serialises it as sync/header/payload bytes for UART TX.
// Define TASK_ANSWER_FRAMER_CHECKSUM_EN to append an XOR checksum byte.
module task_answer_framer
    import task_answer_pkg::*;
#(
    parameter int         FIFO_DEPTH = 256,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_answer_valid,
    input  logic [31:0] i_answer_data,
    input  logic        i_answer_data_last,
    input  logic [31:0] i_answer_size_in_bytes,
    input  logic [31:0] i_answer_latency,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int WCW = $clog2(FIFO_DEPTH) + 1;

    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [WCW-1:0] fifo_count;
    logic [31:0]    head_word;
    logic [31:0]    next_word;

    logic [WCW-1:0] word_cnt;
    logic           capture;

    framer_state_e  state;
    logic           slot_valid;
    answer_desc_t   slot;
    logic [1:0]     byte_idx;
    logic [31:0]    f_size;
    logic [31:0]    f_lat;
    logic [31:0]    rem;
    logic [31:0]    disc;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           overflow;
    logic           xfer;
    logic [31:0]    eff_now;

    assign xfer       = tx_valid & i_tx_ready;
    assign eff_now    = eff_bytes(slot.size, slot.words);
    assign o_tx_data  = tx_data;
    assign o_tx_valid = tx_valid;
    assign o_overflow = overflow;
    assign o_busy     = slot_valid | (state != IDLE);

    answer_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (i_answer_valid),
        .push_data (i_answer_data),
        .pop       (pop),
        .head_data (head_word),
        .next_data (next_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A word arriving in the capture cycle already belongs to the next packet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_cnt <= '0;
            capture  <= 1'b0;
        end else begin
            capture <= i_answer_valid & i_answer_data_last;
            if (capture)             word_cnt <= i_answer_valid ? WCW'(1) : '0;
            else if (i_answer_valid) word_cnt <= word_cnt + WCW'(1);
        end
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            PAYLOAD: pop = xfer & ((byte_idx == 2'd3) | (rem == 32'd1));
            DISCARD: pop = (disc != '0) & ~fifo_empty;
            default: pop = 1'b0;
        endcase
    end

`ifdef TASK_ANSWER_FRAMER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)               csum <= '0;
        else if (state == IDLE)  csum <= '0;
        else if (xfer && (state == SIZE || state == LAT || state == PAYLOAD))
                                 csum <= csum ^ tx_data;
    end
`endif

    // Output byte is always loaded one step ahead so i_tx_ready never reaches o_tx_data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            slot_valid <= 1'b0;
            slot       <= '0;
            byte_idx   <= '0;
            f_size     <= '0;
            f_lat      <= '0;
            rem        <= '0;
            disc       <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (i_answer_valid && fifo_full) overflow <= 1'b1;
            if (capture) begin
                if (slot_valid) begin
                    overflow <= 1'b1;
                end else begin
                    slot_valid <= 1'b1;
                    slot       <= '{words: 32'(word_cnt), size: i_answer_size_in_bytes,
                                    latency: i_answer_latency};
                end
            end
            case (state)
                IDLE: if (slot_valid) begin
                    state    <= SYNC;
                    tx_valid <= 1'b1;
                    tx_data  <= SYNC_BYTE;
                    f_size   <= eff_now;
                    f_lat    <= slot.latency;
                    disc     <= slot.words - ((eff_now + 32'd3) >> 2);
                end
                SYNC: if (xfer) begin
                    state    <= SIZE;
                    byte_idx <= '0;
                    tx_data  <= f_size[7:0];
                end
                SIZE: if (xfer) begin
                    if (byte_idx == 2'd3) begin
                        state    <= LAT;
                        byte_idx <= '0;
                        tx_data  <= f_lat[7:0];
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        tx_data  <= byte_of(f_size, byte_idx + 2'd1);
                    end
                end
                LAT: if (xfer) begin
                    if (byte_idx == 2'd3) begin
                        byte_idx <= '0;
                        rem      <= f_size;
                        if (f_size == '0) begin
                            state    <= DISCARD;
                            tx_valid <= 1'b0;
                        end else begin
                            state    <= PAYLOAD;
                            tx_valid <= ~fifo_empty;
                            tx_data  <= head_word[7:0];
                        end
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        tx_data  <= byte_of(f_lat, byte_idx + 2'd1);
                    end
                end
                PAYLOAD: begin
                    if (!tx_valid) begin
                        if (!fifo_empty) begin
                            tx_valid <= 1'b1;
                            tx_data  <= byte_of(head_word, byte_idx);
                        end
                    end else if (xfer) begin
                        rem <= rem - 32'd1;
                        if (rem == 32'd1) begin
                            state    <= DISCARD;
                            tx_valid <= 1'b0;
                        end else if (byte_idx == 2'd3) begin
                            byte_idx <= '0;
                            tx_valid <= (fifo_count > WCW'(1));
                            tx_data  <= next_word[7:0];
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= byte_of(head_word, byte_idx + 2'd1);
                        end
                    end
                end
                DISCARD: begin
                    if (disc != '0) begin
                        if (!fifo_empty) disc <= disc - 32'd1;
                    end else begin
`ifdef TASK_ANSWER_FRAMER_CHECKSUM_EN
                        state    <= CSUM;
                        tx_valid <= 1'b1;
                        tx_data  <= csum;
`else
                        state      <= IDLE;
                        slot_valid <= 1'b0;
`endif
                    end
                end
`ifdef TASK_ANSWER_FRAMER_CHECKSUM_EN
                CSUM: if (xfer) begin
                    state      <= IDLE;
                    tx_valid   <= 1'b0;
                    slot_valid <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_task_answer_framer.sv
// Scoreboard bench for task_answer_framer (checksum byte expected when TASK_ANSWER_FRAMER_CHECKSUM_EN is defined).
module tb_task_answer_framer;
    import task_answer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        answer_valid   = 1'b0;
    logic [31:0] answer_data    = '0;
    logic        answer_last    = 1'b0;
    logic [31:0] answer_size    = '0;
    logic [31:0] answer_latency = '0;
    logic        tx_ready       = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [7:0]  sb[$];
    bit          toggle_ready  = 1'b0;
    logic        stall_pending = 1'b0;
    logic [7:0]  held_data     = '0;

    always #5 clk = ~clk;

    task_answer_framer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_answer_valid         (answer_valid),
        .i_answer_data          (answer_data),
        .i_answer_data_last     (answer_last),
        .i_answer_size_in_bytes (answer_size),
        .i_answer_latency       (answer_latency),
        .o_tx_data              (tx_data),
        .o_tx_valid             (tx_valid),
        .i_tx_ready             (tx_ready),
        .o_busy                 (busy),
        .o_overflow             (overflow)
    );

    // Payload byte j of every packet is 0x11*(j+1): 11 22 33 44 55 66 77 88 ...
    function automatic logic [7:0] pattern_byte(input int j);
        return 8'((j + 1) * 17);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (toggle_ready) tx_ready = ~tx_ready;
        end
    endtask

    task automatic pushFrame(input int n, input logic [31:0] size, input logic [31:0] lat);
        logic [31:0] cap;
        logic [31:0] eff;
        logic [7:0]  x;
        logic [7:0]  b;
        cap = 32'(4 * n);
        eff = (size < cap) ? size : cap;
        x   = '0;
        sb.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            b = eff[8*i +: 8];
            sb.push_back(b);
            x ^= b;
        end
        for (int i = 0; i < 4; i++) begin
            b = lat[8*i +: 8];
            sb.push_back(b);
            x ^= b;
        end
        for (int j = 0; j < int'(eff); j++) begin
            b = pattern_byte(j);
            sb.push_back(b);
            x ^= b;
        end
`ifdef TASK_ANSWER_FRAMER_CHECKSUM_EN
        sb.push_back(x);
`endif
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] size, input logic [31:0] lat, input bit expect_frame);
        if (expect_frame) pushFrame(n, size, lat);
        for (int k = 0; k < n; k++) begin
            answer_valid   = 1'b1;
            answer_data    = {pattern_byte(4*k+3), pattern_byte(4*k+2), pattern_byte(4*k+1), pattern_byte(4*k)};
            answer_last    = (k == n - 1);
            answer_size    = 32'hDEAD_BEEF;
            answer_latency = 32'hCAFE_F00D;
            runCycles(1);
        end
        answer_valid   = 1'b0;
        answer_last    = 1'b0;
        answer_size    = size;
        answer_latency = lat;
        runCycles(1);
        answer_size    = 32'hDEAD_BEEF;
        answer_latency = 32'hCAFE_F00D;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || busy) && c < budget) begin
            runCycles(1);
            c++;
        end
        checkOutput(tag, 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    // A byte seen valid&ready at the falling edge transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_pending <= 1'b0;
        end else begin
            if (stall_pending) begin
                checkOutput("hold_valid", 32'(tx_valid), 32'd1);
                checkOutput("hold_data", 32'(tx_data), 32'(held_data));
            end
            if (tx_valid && tx_ready) begin
                checkOutput("byte_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) checkOutput("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
            end
            stall_pending <= tx_valid && !tx_ready;
            held_data     <= tx_data;
        end
    end

    initial begin
        int c;
        runCycles(3);
        checkOutput("rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_data", 32'(tx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        runCycles(2);

        $display("[TB] basic frames");
        applyStimulus(2, 32'd8, 32'h10, 1'b1);
        waitDrain("frame_basic", 200);
        applyStimulus(2, 32'd5, 32'h1234_5678, 1'b1);
        waitDrain("frame_short", 200);
        applyStimulus(2, 32'd12, 32'h0000_00FF, 1'b1);
        waitDrain("frame_clamped", 200);
        applyStimulus(1, 32'd0, 32'hA1B2_C3D4, 1'b1);
        waitDrain("frame_empty", 200);
        applyStimulus(3, 32'd10, 32'h7, 1'b1);
        waitDrain("frame_three", 200);
        checkOutput("no_overflow", 32'(overflow), 32'd0);

        $display("[TB] ready toggling");
        toggle_ready = 1'b1;
        applyStimulus(2, 32'd8, 32'h10, 1'b1);
        waitDrain("frame_toggle", 400);
        toggle_ready = 1'b0;
        tx_ready     = 1'b1;

        $display("[TB] overflow");
        tx_ready = 1'b0;
        applyStimulus(5, 32'd20, 32'h55, 1'b0);
        runCycles(1);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        runCycles(6);
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
        checkOutput("busy_stalled", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_clears_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_async_valid", 32'(tx_valid), 32'd0);
        runCycles(2);
        rst      = 1'b0;
        tx_ready = 1'b1;
        runCycles(2);

        $display("[TB] reset mid payload");
        applyStimulus(2, 32'd8, 32'h10, 1'b1);
        c = 0;
        while (sb.size() > 5 && c < 200) begin
            runCycles(1);
            c++;
        end
        checkOutput("reach_payload", 32'(sb.size() <= 5), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", 32'(tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        runCycles(2);
        rst = 1'b0;
        runCycles(2);
        applyStimulus(2, 32'd8, 32'h10, 1'b1);
        waitDrain("frame_after_reset", 200);
        checkOutput("final_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
